circuit: RTL and testbench

CIRCUIT -- requirements
Module: circuit

---
 rtl/circuit_pkg.sv | 25 ++
 rtl/circuit_logic.sv | 17 +
 rtl/circuit.sv | 77 +++++++
 tb/tb_circuit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/circuit_pkg.sv
// Shared constants, the sample record and the pure X/Y equations
// used by the datapath and the result counter.
package circuit_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int CNT_W_MIN = 2;
  localparam int CNT_W_MAX = 16;

  localparam logic [CNT_W_DEF-1:0] CNT_MAX_DEF = '1;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
  } sample_t;

  function automatic logic f_x(input logic a, input logic b, input logic c);
    return (a & b) | c;
  endfunction

  function automatic logic f_y(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

endpackage

// File: rtl/circuit_logic.sv
// Combinational result equations: x = (a & b) | c, y = odd parity of a, b, c.
module circuit_logic
  import circuit_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic x,
  output logic y
);

  always_comb begin
    x = f_x(a, b, c);
    y = f_y(a, b, c);
  end

endmodule

// File: rtl/circuit.sv
// Two-stage registered logic pipeline with a saturating count of X=1 results.
module circuit
  import circuit_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             cnt_clr,
  output logic             X,
  output logic             Y,
  output logic             out_valid,
  output logic [CNT_W-1:0] x_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  sample_t s1_sample;
  logic    s1_valid;
  logic    x_next;
  logic    y_next;
  logic    cnt_inc;

  circuit_logic u_logic (
    .a (s1_sample.a),
    .b (s1_sample.b),
    .c (s1_sample.c),
    .x (x_next),
    .y (y_next)
  );

  // Stage 1: the operand registers only move on an accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sample <= '0;
      s1_valid  <= 1'b0;
    end else begin
      if (in_valid) begin
        s1_sample <= '{a: A, b: B, c: C};
      end
      s1_valid <= in_valid;
    end
  end

  // Stage 2: X/Y hold their last value between result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      X         <= 1'b0;
      Y         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s1_valid) begin
        X <= x_next;
        Y <= y_next;
      end
      out_valid <= s1_valid;
    end
  end

  assign cnt_inc = s1_valid && x_next && (x_count != CNT_MAX);

  // Clear has priority over an increment arriving on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_count <= '0;
    end else if (cnt_clr) begin
      x_count <= '0;
    end else if (cnt_inc) begin
      x_count <= x_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_circuit.sv
// Randomized and directed bench for circuit, checked against a queue-based
// model of scheduled results; drives a default-width and a 2-bit-counter copy.
module tb_circuit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       A = 1'b0;
  logic       B = 1'b0;
  logic       C = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       x8, y8, ov8;
  logic [7:0] cnt8;
  logic       x2, y2, ov2;
  logic [1:0] cnt2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int   due;
    logic x;
    logic y;
  } result_t;

  result_t pend[$];
  logic    exp_x = 1'b0;
  logic    exp_y = 1'b0;
  int      exp_cnt8 = 0;
  int      exp_cnt2 = 0;

  always #5 clk = ~clk;

  circuit u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .C         (C),
    .cnt_clr   (cnt_clr),
    .X         (x8),
    .Y         (y8),
    .out_valid (ov8),
    .x_count   (cnt8)
  );

  circuit #(.CNT_W(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .C         (C),
    .cnt_clr   (cnt_clr),
    .X         (x2),
    .Y         (y2),
    .out_valid (ov2),
    .x_count   (cnt2)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all(input logic exp_ov);
    check("out_valid8", int'(ov8), int'(exp_ov));
    check("out_valid2", int'(ov2), int'(exp_ov));
    check("x8", int'(x8), int'(exp_x));
    check("y8", int'(y8), int'(exp_y));
    check("x2", int'(x2), int'(exp_x));
    check("y2", int'(y2), int'(exp_y));
    check("x_count8", int'(cnt8), exp_cnt8);
    check("x_count2", int'(cnt2), exp_cnt2);
  endtask

  // One clock: present inputs, advance the model at the edge, then compare.
  task automatic cycle(input logic v, input logic a, input logic b, input logic c,
                       input logic clr);
    logic delivered;
    result_t r;
    in_valid = v;
    A = a;
    B = b;
    C = c;
    cnt_clr = clr;
    @(posedge clk);
    cyc++;
    delivered = 1'b0;
    if (rst_n) begin
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        delivered = 1'b1;
        exp_x = r.x;
        exp_y = r.y;
        if (r.x) begin
          exp_cnt8 = (exp_cnt8 + 1 > 255) ? 255 : exp_cnt8 + 1;
          exp_cnt2 = (exp_cnt2 + 1 > 3) ? 3 : exp_cnt2 + 1;
        end
      end
      if (clr) begin
        exp_cnt8 = 0;
        exp_cnt2 = 0;
      end
      if (v) pend.push_back('{cyc + 1, (a & b) | c, a ^ b ^ c});
    end
    #1;
    check_all(delivered);
    if (delivered)
      $display("cyc=%0d result X=%0b Y=%0b x_count8=%0d x_count2=%0d",
               cyc, x8, y8, cnt8, cnt2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] bits;
    #3;
    check_all(1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // First sample right after release, all zeros
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Back-to-back 101, 011, 110
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("x_count8_after_three", int'(cnt8), 3);

    // Sweep all combinations with gaps of garbage inputs
    for (int i = 0; i < 8; i++) begin
      bits = 3'(i);
      cycle(1'b1, bits[2], bits[1], bits[0], 1'b0);
      cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end

    // Saturation of the narrow counter, then clear beats a concurrent X=1 result
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    check("x_count2_saturated", int'(cnt2), 3);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("x_count2_clr_wins", int'(cnt2), 0);
    idle(2);

    // Idle inputs toggling: nothing may change
    for (int i = 0; i < 10; i++)
      cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    // Reset one cycle after a 111 sample is accepted
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    pend.delete();
    exp_x = 1'b0;
    exp_y = 1'b0;
    exp_cnt8 = 0;
    exp_cnt2 = 0;
    check_all(1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom_range(0, 15) == 0));
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
